// File: rtl/demux_frame_router_if.sv
// Handshake and demux-side signals of demux_frame_router, grouped for port use.
// master = frame source / demux side, slave = the router itself.
interface demux_frame_router_if;
    logic       hdr_valid;
    logic       hdr_ready;
    logic [2:0] hdr_ch;
    logic [3:0] hdr_len;
    logic       byte_valid;
    logic       byte_ready;
    logic [7:0] byte_data;
    logic       s0;
    logic       s1;
    logic       s2;
    logic       in;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output hdr_valid, hdr_ch, hdr_len, byte_valid, byte_data,
        input  hdr_ready, byte_ready, s0, s1, s2, in, busy, done, err
    );

    modport slave (
        input  hdr_valid, hdr_ch, hdr_len, byte_valid, byte_data,
        output hdr_ready, byte_ready, s0, s1, s2, in, busy, done, err
    );
endinterface

// File: rtl/demux_frame_router.sv
// Frames a header plus payload bytes into an MSB-first serial stream for the 1-to-8 demux,
// holding the selects for the whole frame. Define DEMUX_ROUTER_PARITY_EN for a per-byte even-parity bit.
module demux_frame_router #(
    parameter int unsigned MAX_LEN = 15
) (
    input logic                  clk,
    input logic                  rst,
    demux_frame_router_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

`ifdef DEMUX_ROUTER_PARITY_EN
    localparam logic [3:0] LAST_BIT = 4'd8;
`else
    localparam logic [3:0] LAST_BIT = 4'd7;
`endif

    state_t     state;
    logic [2:0] sel;
    logic [3:0] count;
    logic [3:0] bit_idx;
    logic [6:0] shreg;
`ifdef DEMUX_ROUTER_PARITY_EN
    logic       parity;
`endif

    logic hdr_fire;
    logic byte_fire;
    logic len_ok;

    assign hdr_fire  = bus.hdr_valid && bus.hdr_ready;
    // byte_ready is only ever high in LOAD or the final SHIFT cycle, so a fire always means "start a byte".
    assign byte_fire = bus.byte_valid && bus.byte_ready;
    assign len_ok    = (bus.hdr_len != 4'd0) && (32'(bus.hdr_len) <= MAX_LEN);

    assign {bus.s2, bus.s1, bus.s0} = sel;

    // NOTE: one clocked block with non-blocking assignments keeps every output a flop; the pulse
    // defaults at the top are legally overridden further down in the same block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            sel            <= 3'd0;
            count          <= 4'd0;
            bit_idx        <= 4'd0;
            shreg          <= 7'd0;
`ifdef DEMUX_ROUTER_PARITY_EN
            parity         <= 1'b0;
`endif
            bus.hdr_ready  <= 1'b0;
            bus.byte_ready <= 1'b0;
            bus.in         <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            bus.err  <= 1'b0;
            bus.done <= 1'b0;

            if (byte_fire) begin
                state          <= SHIFT;
                shreg          <= bus.byte_data[6:0];
                bus.in         <= bus.byte_data[7];
                bit_idx        <= 4'd0;
                count          <= count - 4'd1;
                bus.byte_ready <= 1'b0;
`ifdef DEMUX_ROUTER_PARITY_EN
                parity         <= ^bus.byte_data;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        bus.hdr_ready <= 1'b1;
                        if (hdr_fire) begin
                            if (len_ok) begin
                                sel            <= bus.hdr_ch;
                                count          <= bus.hdr_len;
                                state          <= LOAD;
                                bus.hdr_ready  <= 1'b0;
                                bus.byte_ready <= 1'b1;
                                bus.busy       <= 1'b1;
                            end else begin
                                bus.err <= 1'b1;
                            end
                        end
                    end

                    LOAD: ;

                    SHIFT: begin
                        if (bit_idx != LAST_BIT) begin
                            bit_idx        <= bit_idx + 4'd1;
                            shreg          <= {shreg[5:0], 1'b0};
`ifdef DEMUX_ROUTER_PARITY_EN
                            bus.in         <= (bit_idx == LAST_BIT - 4'd1) ? parity : shreg[6];
`else
                            bus.in         <= shreg[6];
`endif
                            // Lookahead: offer the next byte during the final bit cycle.
                            bus.byte_ready <= (bit_idx == LAST_BIT - 4'd1) && (count != 4'd0);
                        end else if (count != 4'd0) begin
                            state          <= LOAD;
                            bus.in         <= 1'b0;
                            bus.byte_ready <= 1'b1;
                        end else begin
                            state          <= GAP;
                            bus.in         <= 1'b0;
                            bus.byte_ready <= 1'b0;
                            bus.done       <= 1'b1;
                        end
                    end

                    GAP: begin
                        state         <= IDLE;
                        bus.busy      <= 1'b0;
                        bus.hdr_ready <= 1'b1;
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
